// File: rtl/row_access_pkg.sv
// Shared types and constants for the row access controller.
//   state_e : controller phase (IDLE, DECODE, ACCESS, PRECHARGE)
//   ADDR_W  : default decoder address width
//   NROWS   : rows reachable with the default address width
package row_access_pkg;
  localparam int ADDR_W = 4;
  localparam int NROWS  = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    ACCESS    = 2'd2,
    PRECHARGE = 2'd3
  } state_e;
endpackage

// File: rtl/row_access_ctrl_phase_timer.sv
// Loadable down-counter used to time the ACCESS and PRECHARGE phases.
//   clk, reset : clock, async active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : remaining cycles minus one for the phase being entered
//   cnt        : current count
//   expire     : count has reached zero (last cycle of the phase)
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/row_access_ctrl.sv
// Single-row access sequencer feeding a one-hot row decoder.
// Handles valid/ready read/write requests and a self-timed read scan of
// every row; drives decoder address, wordline enable, write enable and
// bitline precharge, all from registers.
//   clk, reset            : clock, async active-high reset
//   req_valid/req_ready   : request handshake
//   req_addr, req_write   : row and direction, sampled on acceptance
//   scan_start, scan_busy : start / status of a full read scan
//   dec_a, wl_en, we      : decoder address, wordline enable, write enable
//   precharge             : bitline precharge
//   done, done_addr       : one-cycle completion pulse and its row
module row_access_ctrl #(
  parameter int ADDR_W           = row_access_pkg::ADDR_W,
  parameter int ACCESS_CYCLES    = 2,
  parameter int PRECHARGE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic [ADDR_W-1:0] dec_a,
  output logic              wl_en,
  output logic              we,
  output logic              precharge,
  output logic              done,
  output logic [ADDR_W-1:0] done_addr
);
  import row_access_pkg::state_e;
  import row_access_pkg::IDLE;
  import row_access_pkg::DECODE;
  import row_access_pkg::ACCESS;
  import row_access_pkg::PRECHARGE;

  localparam int MAXC = (ACCESS_CYCLES > PRECHARGE_CYCLES) ? ACCESS_CYCLES : PRECHARGE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] ACC_LD = TW'(ACCESS_CYCLES - 1);
  localparam logic [TW-1:0] PRE_LD = TW'(PRECHARGE_CYCLES - 1);

  state_e state, state_n;

  logic          ready_q, wr_q;
  logic          t_load, t_expire;
  logic [TW-1:0] t_val, t_cnt;

  logic [ADDR_W-1:0] dec_a_d, done_addr_d;
  logic wr_d, busy_d, wl_en_d, we_d, precharge_d, done_d, ready_d;

  // A simultaneous scan_start wins over a pending request, so the ready
  // flag is masked in that cycle; outside IDLE ready_q is already 0.
  assign req_ready = ready_q & ~scan_start;

  // Timer is (re)loaded whenever a timed phase is entered.
  assign t_load = (state_n != state) && (state_n == ACCESS || state_n == PRECHARGE);
  assign t_val  = (state_n == ACCESS) ? ACC_LD : PRE_LD;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .cnt      (t_cnt),
    .expire   (t_expire)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (scan_start || (req_valid && req_ready)) state_n = DECODE;
      DECODE:    state_n = ACCESS;
      ACCESS:    if (t_expire) state_n = PRECHARGE;
      PRECHARGE: if (t_expire) state_n = (scan_busy && !(&dec_a)) ? DECODE : IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    dec_a_d = dec_a;
    wr_d    = wr_q;
    busy_d  = scan_busy;
    if (state == IDLE) begin
      if (scan_start) begin
        dec_a_d = '0;
        wr_d    = 1'b0;
        busy_d  = 1'b1;
      end else if (req_valid && req_ready) begin
        dec_a_d = req_addr;
        wr_d    = req_write;
      end
    end
    // Only address change outside IDLE: scan advance after precharge,
    // so dec_a holds from DECODE through the end of PRECHARGE.
    if (state == PRECHARGE && t_expire) begin
      if (scan_busy && !(&dec_a)) dec_a_d = dec_a + ADDR_W'(1);
      else                        busy_d  = 1'b0;
    end
    wl_en_d     = (state_n == ACCESS);
    we_d        = (state_n == ACCESS) && wr_q;
    precharge_d = (state_n == IDLE) || (state_n == PRECHARGE);
    ready_d     = (state_n == IDLE);
    // done lands on the last PRECHARGE cycle: either entered with a zero
    // load, or counting down to zero from one.
    done_d      = (state_n == PRECHARGE) && (t_load ? (t_val == '0) : (t_cnt == TW'(1)));
    done_addr_d = done_d ? dec_a : done_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_a     <= '0;
      wr_q      <= 1'b0;
      scan_busy <= 1'b0;
      wl_en     <= 1'b0;
      we        <= 1'b0;
      precharge <= 1'b1;
      ready_q   <= 1'b1;
      done      <= 1'b0;
      done_addr <= '0;
    end else begin
      dec_a     <= dec_a_d;
      wr_q      <= wr_d;
      scan_busy <= busy_d;
      wl_en     <= wl_en_d;
      we        <= we_d;
      precharge <= precharge_d;
      ready_q   <= ready_d;
      done      <= done_d;
      done_addr <= done_addr_d;
    end
  end

endmodule

// File: tb/tb_row_access_ctrl.sv
// Directed bench for row_access_ctrl: default timing instance plus an
// ACCESS_CYCLES=1 / PRECHARGE_CYCLES=3 instance driven in parallel.
module tb_row_access_ctrl;
  logic clk = 1'b0;
  logic reset;

  logic       req_valid, req_write, scan_start;
  logic [3:0] req_addr;
  logic       req_ready, scan_busy, wl_en, we, precharge, done;
  logic [3:0] dec_a, done_addr;

  logic       a_req_valid, a_req_write, a_scan_start;
  logic [3:0] a_req_addr;
  logic       a_req_ready, a_scan_busy, a_wl_en, a_we, a_precharge, a_done;
  logic [3:0] a_dec_a, a_done_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  row_access_ctrl u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .scan_start(scan_start), .scan_busy(scan_busy),
    .dec_a(dec_a), .wl_en(wl_en), .we(we), .precharge(precharge),
    .done(done), .done_addr(done_addr)
  );

  row_access_ctrl #(.ACCESS_CYCLES(1), .PRECHARGE_CYCLES(3)) u_alt (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr), .req_write(a_req_write),
    .scan_start(a_scan_start), .scan_busy(a_scan_busy),
    .dec_a(a_dec_a), .wl_en(a_wl_en), .we(a_we), .precharge(a_precharge),
    .done(a_done), .done_addr(a_done_addr)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle invariants: wordline and precharge exclusive, address
  // frozen while the wordline is on.
  logic       prev_wl = 1'b0;
  logic [3:0] prev_a  = '0;
  always @(negedge clk) begin
    chk("wl_pc_excl", int'(wl_en & precharge), 0);
    chk("alt_wl_pc_excl", int'(a_wl_en & a_precharge), 0);
    if (wl_en && prev_wl) chk("dec_a_stable", int'(dec_a), int'(prev_a));
    prev_wl <= wl_en;
    prev_a  <= dec_a;
  end

  initial begin
    int wl_cnt, bad_we, bad_ready, bad_order, nd, busy_cyc, ndone, wl_seen;
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; scan_start = 0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_scan_start = 0;

    // Reset state
    #2;
    chk("rst_dec_a", int'(dec_a), 0);
    chk("rst_wl_en", int'(wl_en), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_precharge", int'(precharge), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_done_addr", int'(done_addr), 0);
    chk("rst_scan_busy", int'(scan_busy), 0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("rst_ready", int'(req_ready), 1);

    // Test 1: write row A on both instances
    req_valid = 1; req_addr = 4'hA; req_write = 1;
    a_req_valid = 1; a_req_addr = 4'hA; a_req_write = 1;
    tick(); // cycle 1
    req_valid = 0; a_req_valid = 0;
    chk("t1_c1_dec_a", int'(dec_a), 10);
    chk("t1_c1_wl_en", int'(wl_en), 0);
    chk("t1_c1_precharge", int'(precharge), 0);
    chk("t1_c1_ready", int'(req_ready), 0);
    chk("alt_c1_dec_a", int'(a_dec_a), 10);
    tick(); // cycle 2
    chk("t1_c2_wl_en", int'(wl_en), 1);
    chk("t1_c2_we", int'(we), 1);
    chk("alt_c2_wl_en", int'(a_wl_en), 1);
    chk("alt_c2_we", int'(a_we), 1);
    tick(); // cycle 3
    chk("t1_c3_wl_en", int'(wl_en), 1);
    chk("t1_c3_we", int'(we), 1);
    chk("alt_c3_wl_en", int'(a_wl_en), 0);
    chk("alt_c3_precharge", int'(a_precharge), 1);
    chk("alt_c3_done", int'(a_done), 0);
    tick(); // cycle 4
    chk("t1_c4_wl_en", int'(wl_en), 0);
    chk("t1_c4_we", int'(we), 0);
    chk("t1_c4_precharge", int'(precharge), 1);
    chk("t1_c4_done", int'(done), 1);
    chk("t1_c4_done_addr", int'(done_addr), 10);
    chk("t1_c4_ready", int'(req_ready), 0);
    chk("alt_c4_done", int'(a_done), 0);
    tick(); // cycle 5
    chk("t1_c5_ready", int'(req_ready), 1);
    chk("t1_c5_done", int'(done), 0);
    chk("alt_c5_done", int'(a_done), 1);
    chk("alt_c5_done_addr", int'(a_done_addr), 10);
    chk("alt_c5_ready", int'(a_req_ready), 0);
    tick(); // cycle 6
    chk("alt_c6_ready", int'(a_req_ready), 1);
    chk("alt_c6_done", int'(a_done), 0);

    // Test 2: back-to-back reads of row 3
    req_valid = 1; req_addr = 4'h3; req_write = 0;
    wl_cnt = 0; bad_we = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (wl_en) wl_cnt++;
      if (we) bad_we++;
      if (i == 4) chk("t2_done1", int'(done) * 16 + int'(done_addr), 16 + 3);
      if (i == 4) chk("t2_c4_ready", int'(req_ready), 0);
      if (i == 5) chk("t2_c5_ready", int'(req_ready), 1);
      if (i == 6) chk("t2_c6_dec_a", int'(dec_a), 3);
      if (i == 6) chk("t2_c6_ready", int'(req_ready), 0);
      if (i == 9) chk("t2_done2", int'(done) * 16 + int'(done_addr), 16 + 3);
    end
    req_valid = 0;
    chk("t2_wl_cycles", wl_cnt, 4);
    chk("t2_we_low", bad_we, 0);
    tick(); // back in IDLE

    // Test 3: full scan
    chk("t3_pre_ready", int'(req_ready), 1);
    scan_start = 1;
    tick();
    scan_start = 0;
    chk("t3_busy", int'(scan_busy), 1);
    chk("t3_dec_a0", int'(dec_a), 0);
    nd = 0; bad_ready = 0; bad_we = 0; bad_order = 0;
    for (int c = 1; c <= 64; c++) begin
      if (c > 1) tick();
      if (req_ready) bad_ready++;
      if (we) bad_we++;
      if (done) begin
        if (int'(done_addr) != nd || c != 4 + 4 * nd) bad_order++;
        nd++;
      end
    end
    chk("t3_done_count", nd, 16);
    chk("t3_done_order", bad_order, 0);
    chk("t3_ready_low", bad_ready, 0);
    chk("t3_we_low", bad_we, 0);
    chk("t3_busy_last", int'(scan_busy), 1);
    tick();
    chk("t3_busy_end", int'(scan_busy), 0);
    chk("t3_ready_end", int'(req_ready), 1);
    chk("t3_no_wrap", int'(dec_a), 15);

    // Test 4: scan and request together; scan_start repeated mid-scan
    scan_start = 1; req_valid = 1; req_addr = 4'h5; req_write = 1;
    #1;
    chk("t4_ready_forced", int'(req_ready), 0);
    tick();
    scan_start = 0;
    chk("t4_busy", int'(scan_busy), 1);
    chk("t4_dec_a0", int'(dec_a), 0);
    busy_cyc = 0; bad_ready = 0;
    while (scan_busy && busy_cyc < 200) begin
      busy_cyc++;
      if (req_ready) bad_ready++;
      scan_start = (busy_cyc == 10);
      tick();
    end
    scan_start = 0;
    chk("t4_busy_cycles", busy_cyc, 64);
    chk("t4_ready_low", bad_ready, 0);
    chk("t4_ready_after", int'(req_ready), 1);
    tick();
    req_valid = 0;
    chk("t4_req_dec_a", int'(dec_a), 5);
    tick();
    chk("t4_req_wl_we", int'(wl_en) * 2 + int'(we), 3);
    tick();
    tick();
    chk("t4_req_done", int'(done) * 16 + int'(done_addr), 16 + 5);
    tick();

    // Test 5: asynchronous reset during ACCESS of row 7
    req_valid = 1; req_addr = 4'h7; req_write = 0;
    tick();
    req_valid = 0;
    tick();
    chk("t5_in_access", int'(wl_en), 1);
    chk("t5_dec_a", int'(dec_a), 7);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_wl_en", int'(wl_en), 0);
    chk("t5_rst_precharge", int'(precharge), 1);
    chk("t5_rst_dec_a", int'(dec_a), 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    ndone = 0; wl_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
      if (wl_en) wl_seen++;
    end
    chk("t5_no_done", ndone, 0);
    chk("t5_no_wl", wl_seen, 0);
    chk("t5_idle_ready", int'(req_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
